// File: rtl/queue_slot_ctrl_pkg.sv
// Shared definitions for the slot-queue bookkeeping stage: default depth and FSM state encodings.
// QUEUE_DEPTH may be overridden by defining the QUEUE_DEPTH macro before this file.
`ifndef QUEUE_DEPTH
`define QUEUE_DEPTH 8
`endif

package queue_slot_ctrl_pkg;

    localparam int QSC_DEFAULT_DEPTH = `QUEUE_DEPTH;

    typedef enum logic [1:0] {
        QSC_EMPTY   = 2'd0,
        QSC_PARTIAL = 2'd1,
        QSC_FULL    = 2'd2
    } qsc_state_e;

endpackage

// File: rtl/onehot_ring_ptr.sv
// One-hot slot pointer that rotates left by one position per advance, wrapping MSB to bit 0.
// Reset and clear both return the pointer to slot 0.
module onehot_ring_ptr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_q <= WIDTH'(1);
        end else if (advance) begin
            ptr_q <= {ptr_q[WIDTH-2:0], ptr_q[WIDTH-1]};
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/queue_slot_ctrl.sv
// Slot-queue bookkeeping: occupancy bitmap, one-hot write/read pointers, FIFO-order acceptance.
// Optional entry counter and occupancy port enabled by defining QSC_OCCUPANCY_EN.
module queue_slot_ctrl
    import queue_slot_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = QSC_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic                   flush,
    output logic [QUEUE_DEPTH-1:0] status,
    output logic [QUEUE_DEPTH-1:0] wr_sel,
    output logic [QUEUE_DEPTH-1:0] rd_sel,
    output logic                   wr_ack,
    output logic                   rd_ack,
    output logic                   ovf_err,
    output logic                   udf_err
`ifdef QSC_OCCUPANCY_EN
    ,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
`endif
);

    logic [QUEUE_DEPTH-1:0] status_q, status_d;
    logic [QUEUE_DEPTH-1:0] wr_ptr, rd_ptr;
    qsc_state_e             state_q, state_d;
    logic                   ovf_err_q, ovf_err_d;
    logic                   udf_err_q, udf_err_d;

    onehot_ring_ptr #(.WIDTH(QUEUE_DEPTH)) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .advance (wr_ack),
        .ptr     (wr_ptr)
    );

    onehot_ring_ptr #(.WIDTH(QUEUE_DEPTH)) u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .advance (rd_ack),
        .ptr     (rd_ptr)
    );

    // Acceptance looks only at the addressed slot, so a full queue never writes through a same-cycle read.
    assign wr_ack = wr_en & ~flush & ~|(status_q & wr_ptr);
    assign rd_ack = rd_en & ~flush &  |(status_q & rd_ptr);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status_d  = status_q;
        state_d   = state_q;
        ovf_err_d = ovf_err_q | (wr_en & ~flush & (state_q == QSC_FULL));
        udf_err_d = udf_err_q | (rd_en & ~flush & (state_q == QSC_EMPTY));

        if (flush) begin
            status_d = '0;
            state_d  = QSC_EMPTY;
        end else begin
            if (wr_ack) status_d = status_d | wr_ptr;
            if (rd_ack) status_d = status_d & ~rd_ptr;

            unique case (state_q)
                QSC_EMPTY: begin
                    if (wr_ack) state_d = QSC_PARTIAL;
                end
                QSC_PARTIAL: begin
                    if (wr_ack && !rd_ack && (&(status_q | wr_ptr))) begin
                        state_d = QSC_FULL;
                    end else if (rd_ack && !wr_ack && ((status_q & ~rd_ptr) == '0)) begin
                        state_d = QSC_EMPTY;
                    end
                end
                QSC_FULL: begin
                    if (rd_ack) state_d = QSC_PARTIAL;
                end
                default: state_d = QSC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q  <= '0;
            state_q   <= QSC_EMPTY;
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            state_q   <= state_d;
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign status  = status_q;
    assign wr_sel  = wr_ptr;
    assign rd_sel  = rd_ptr;
    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;

`ifdef QSC_OCCUPANCY_EN
    localparam int OCC_W = $clog2(QUEUE_DEPTH) + 1;

    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    always_comb begin
        occupancy_d = occupancy_q;
        if (flush) begin
            occupancy_d = '0;
        end else if (wr_ack && !rd_ack) begin
            occupancy_d = occupancy_q + OCC_W'(1);
        end else if (rd_ack && !wr_ack) begin
            occupancy_d = occupancy_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;
`endif

endmodule
